// File: rtl/convolve_fpga_pkg.sv
// Shared definitions for the convolve_fpga multiplier-sharing slice:
// operand/product widths, core latency and the in-flight owner tag.
package convolve_fpga_pkg;

    localparam int unsigned MUL_A_W  = 8;   // unsigned pixel operand
    localparam int unsigned MUL_B_W  = 16;  // signed coefficient
    localparam int unsigned MUL_P_W  = 16;  // truncated product
    localparam int unsigned MUL_LAT  = 3;   // core edges, operands to dout
    localparam int unsigned MUL_ID_W = 3;   // owner tag field, covers up to 8 lanes

    typedef struct packed {
        logic                valid;
        logic [MUL_ID_W-1:0] id;
    } mul_tag_t;

endpackage

// File: rtl/convolve_fpga_mul_mul_8ns_16s_16_4_1.sv
// Pipelined unsigned x signed multiplier core with clock enable. Operands are
// registered, then the truncated product passes NUM_STAGE-2 output registers,
// so dout reflects operands NUM_STAGE-1 enabled edges later. Data registers
// are intentionally not reset; the owner of this core masks them with tags.
module convolve_fpga_mul_mul_8ns_16s_16_4_1 #(
    parameter int unsigned NUM_STAGE  = 4,
    parameter int unsigned din0_WIDTH = 8,
    parameter int unsigned din1_WIDTH = 16,
    parameter int unsigned dout_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);

    logic        [din0_WIDTH-1:0] r_a;
    logic signed [din1_WIDTH-1:0] r_b;
    logic        [dout_WIDTH-1:0] r_p [NUM_STAGE-2];
    logic signed [dout_WIDTH-1:0] w_a_x;
    logic signed [dout_WIDTH-1:0] w_b_x;
    logic signed [dout_WIDTH-1:0] w_p;
    logic                         w_reset_unused;

    assign w_reset_unused = reset;

    // Only the low dout_WIDTH bits are kept, so the operands are extended
    // (zero for a, sign for b) straight to that width before multiplying.
    assign w_a_x = dout_WIDTH'($signed({1'b0, r_a}));
    assign w_b_x = dout_WIDTH'(r_b);
    assign w_p   = w_a_x * w_b_x;

    // Operand capture and product pipeline, all advancing only on ce.
    always_ff @(posedge clk) begin
        if (ce) begin
            r_a    <= din0;
            r_b    <= din1;
            r_p[0] <= w_p;
            for (int unsigned k = 1; k < NUM_STAGE - 2; k++) begin
                r_p[k] <= r_p[k-1];
            end
        end
    end

    assign dout = r_p[NUM_STAGE-3];

endmodule

// File: rtl/convolve_fpga_rr_pick.sv
// Combinational round-robin picker: first requesting lane at or after the
// pointer, searching modulo NUM_REQ. Produces one-hot grant and its index.
module convolve_fpga_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    // Scan lanes starting at the pointer; the first hit wins.
    always_comb begin
        int unsigned v_lane;
        v_lane  = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_lane = (32'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[v_lane]) begin
                o_any           = 1'b1;
                o_grant[v_lane] = 1'b1;
                o_idx           = ID_W'(v_lane);
            end
        end
    end

endmodule

// File: rtl/convolve_fpga_mul_arbiter.sv
// Shares one pipelined multiplier core among NUM_REQ convolution lanes.
// A tag pipeline of {valid, id} runs in lockstep with the core so each
// product returns to the lane that issued it; a non-ready head owner stalls
// both the tags and the core via ce.
// Optional: define CONVOLVE_FPGA_MUL_ARB_PRIO0_EN to give lane 0 strict
// priority (rr untouched by its grants); otherwise pure round-robin.
module convolve_fpga_mul_arbiter
    import convolve_fpga_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned MUL_LAT = convolve_fpga_pkg::MUL_LAT,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*MUL_A_W-1:0] req_a,
    input  logic [NUM_REQ*MUL_B_W-1:0] req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [MUL_P_W-1:0]         rsp_data,
    output logic                       busy
);

    mul_tag_t             r_tag     [MUL_LAT];
    mul_tag_t             w_tag_nxt [MUL_LAT];
    logic [ID_W-1:0]      r_rr;
    logic [ID_W-1:0]      w_rr_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [ID_W-1:0]      w_pick_idx;
    logic                 w_pick_any;
    logic [NUM_REQ-1:0]   w_win_oh;
    logic [ID_W-1:0]      w_win_idx;
    logic                 w_grant;
    logic [NUM_REQ-1:0]   w_head_oh;
    logic                 w_head_valid;
    logic                 w_ce;
    logic [MUL_A_W-1:0]   w_din0;
    logic [MUL_B_W-1:0]   w_din1;

    convolve_fpga_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_rr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Head decode and stall: hold everything while the head owner is not ready.
    always_comb begin
        w_head_valid = r_tag[MUL_LAT-1].valid;
        w_head_oh    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_head_oh[i] = w_head_valid && (r_tag[MUL_LAT-1].id == MUL_ID_W'(i));
        end
        w_ce = !(w_head_valid && ((w_head_oh & rsp_ready) == '0));
    end

    // Winner selection, pointer advance and operand mux.
    always_comb begin
        w_grant = w_ce && w_pick_any;
`ifdef CONVOLVE_FPGA_MUL_ARB_PRIO0_EN
        if (req_valid[0]) begin
            w_win_idx = '0;
            w_win_oh  = NUM_REQ'(1);
        end else begin
            w_win_idx = w_pick_idx;
            w_win_oh  = w_pick_oh;
        end
`else
        w_win_idx = w_pick_idx;
        w_win_oh  = w_pick_oh;
`endif
        w_rr_nxt = r_rr;
`ifdef CONVOLVE_FPGA_MUL_ARB_PRIO0_EN
        if (w_grant && !req_valid[0]) begin
`else
        if (w_grant) begin
`endif
            w_rr_nxt = (w_win_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_win_idx + ID_W'(1);
        end
        req_ready = w_win_oh & {NUM_REQ{w_grant && !reset}};
        w_din0    = req_a[32'(w_win_idx) * MUL_A_W +: MUL_A_W];
        w_din1    = req_b[32'(w_win_idx) * MUL_B_W +: MUL_B_W];
    end

    // Next tag pipeline contents; busy is registered from the next valids so it
    // tracks the stage valids of the same cycle.
    always_comb begin
        w_tag_nxt[0] = '{valid: w_grant, id: MUL_ID_W'(w_win_idx)};
        for (int unsigned k = 1; k < MUL_LAT; k++) begin
            w_tag_nxt[k] = r_tag[k-1];
        end
        if (!w_ce) begin
            for (int unsigned k = 0; k < MUL_LAT; k++) begin
                w_tag_nxt[k] = r_tag[k];
            end
        end
        w_busy_nxt = 1'b0;
        for (int unsigned k = 0; k < MUL_LAT; k++) begin
            w_busy_nxt = w_busy_nxt | w_tag_nxt[k].valid;
        end
    end

    // Tag pipeline, round-robin pointer and busy flag state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < MUL_LAT; k++) begin
                r_tag[k] <= '{valid: 1'b0, id: '0};
            end
            r_rr   <= '0;
            r_busy <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < MUL_LAT; k++) begin
                r_tag[k] <= w_tag_nxt[k];
            end
            r_rr   <= w_rr_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    convolve_fpga_mul_mul_8ns_16s_16_4_1 #(
        .NUM_STAGE  (MUL_LAT + 1),
        .din0_WIDTH (MUL_A_W),
        .din1_WIDTH (MUL_B_W),
        .dout_WIDTH (MUL_P_W)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .ce    (w_ce),
        .din0  (w_din0),
        .din1  (w_din1),
        .dout  (rsp_data)
    );

    assign rsp_valid = w_head_oh;
    assign busy      = r_busy;

endmodule

// File: tb/tb_convolve_fpga_mul_arbiter.sv
// Self-checking bench for convolve_fpga_mul_arbiter (4 lanes, latency 3).
// Reference model: queue of in-flight products stamped with the count of
// enabled cycles at grant; a product is at the head once LAT more enabled
// cycles have elapsed.
module tb_convolve_fpga_mul_arbiter;

    localparam int NR  = 4;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          lane;
        logic [15:0] prod;
        int          t;
    } ent_t;

    ent_t q[$];
    int   adv  = 0;
    int   m_rr = 0;

    logic [3:0]  s_req_ready;
    logic [3:0]  s_rsp_valid;
    logic [15:0] s_rsp_data;

    convolve_fpga_mul_arbiter #(
        .NUM_REQ (4),
        .MUL_LAT (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [15:0] b);
        int p;
        p = int'(a) * int'($signed(b));
        return p[15:0];
    endfunction

    task automatic set_op(input int l, input logic [7:0] a, input logic [15:0] b);
        req_a[l*8 +: 8]   = a;
        req_b[l*16 +: 16] = b;
    endtask

    task automatic rand_ops();
        req_a = $urandom();
        req_b = {$urandom(), $urandom()};
    endtask

    task automatic model_reset();
        q.delete();
        m_rr = 0;
    endtask

    // One clock cycle: compare DUT against the model at negedge, advance model.
    task automatic cycle();
        logic       hd;
        int         hl;
        logic       mce;
        int         w;
        logic [3:0] er;
        logic [3:0] ev;
        @(negedge clk);
        s_req_ready = req_ready;
        s_rsp_valid = rsp_valid;
        s_rsp_data  = rsp_data;
        hd  = (q.size() != 0) && (q[0].t + LAT == adv);
        hl  = hd ? q[0].lane : 0;
        ev  = hd ? 4'(1 << hl) : 4'b0;
        mce = !(hd && !rsp_ready[hl]);
        w   = -1;
        if (mce) begin
`ifdef CONVOLVE_FPGA_MUL_ARB_PRIO0_EN
            if (req_valid[0]) w = 0;
`endif
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && req_valid[(m_rr + k) % NR]) w = (m_rr + k) % NR;
            end
        end
        er = (w >= 0) ? 4'(1 << w) : 4'b0;

        n_checks++;
        if (s_req_ready !== er) begin
            n_fail++;
            $display("FAIL req_ready t=%0t got=%b exp=%b", $time, s_req_ready, er);
        end
        n_checks++;
        if (s_rsp_valid !== ev) begin
            n_fail++;
            $display("FAIL rsp_valid t=%0t got=%b exp=%b", $time, s_rsp_valid, ev);
        end
        n_checks++;
        if (busy !== (q.size() != 0)) begin
            n_fail++;
            $display("FAIL busy t=%0t got=%b exp=%b", $time, busy, (q.size() != 0));
        end
        if (hd) begin
            n_checks++;
            if (s_rsp_data !== q[0].prod) begin
                n_fail++;
                $display("FAIL rsp_data t=%0t lane=%0d got=%h exp=%h", $time, hl, s_rsp_data, q[0].prod);
            end
        end

        if (mce) begin
            if (hd) void'(q.pop_front());
            if (w >= 0) begin
                q.push_back('{lane: w, prod: ref_mul(req_a[w*8 +: 8], req_b[w*16 +: 16]), t: adv});
`ifdef CONVOLVE_FPGA_MUL_ARB_PRIO0_EN
                if (w != 0 || !req_valid[0]) m_rr = (w + 1) % NR;
`else
                m_rr = (w + 1) % NR;
`endif
            end
            adv++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = 4'b0;
        rsp_ready = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        n_checks++;
        if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        req_valid = 4'b1111;
        #1;
        n_checks++;
        if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_gate_ready got=%b exp=0000", req_ready); end
        req_valid = 4'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        repeat (4) cycle();
        set_op(2, 8'd200, 16'hFFFD);
        req_valid = 4'b0100;
        cycle();
        n_checks++;
        if (s_req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", s_req_ready); end
        req_valid = 4'b0;
        repeat (3) cycle();
        n_checks++;
        if (s_rsp_valid !== 4'b0100) begin n_fail++; $display("FAIL single_rsp_valid got=%b exp=0100", s_rsp_valid); end
        n_checks++;
        if (s_rsp_data !== 16'hFDA8) begin n_fail++; $display("FAIL single_rsp_data got=%h exp=fda8", s_rsp_data); end
        repeat (2) cycle();
    endtask

    task automatic test_round_robin();
        rsp_ready = 4'b1111;
        req_valid = 4'b1111;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            cycle();
        end
        req_valid = 4'b0;
        repeat (4) cycle();
    endtask

    task automatic test_wrap();
        set_op(1, 8'd255, 16'd32767);
        req_valid = 4'b0010;
        cycle();
        req_valid = 4'b0;
        repeat (3) cycle();
        n_checks++;
        if (s_rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL wrap_rsp_valid got=%b exp=0010", s_rsp_valid); end
        n_checks++;
        if (s_rsp_data !== 16'h7F01) begin n_fail++; $display("FAIL wrap_rsp_data got=%h exp=7f01", s_rsp_data); end
        cycle();
    endtask

    task automatic test_stall();
        pulse_reset();
        set_op(0, 8'd9,   16'd9);
        set_op(1, 8'd17,  16'hFC18);
        set_op(2, 8'd3,   16'd5);
        set_op(3, 8'd250, 16'd300);
        rsp_ready = 4'b1101;
        req_valid = 4'b1110;
        repeat (3) cycle();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (s_req_ready !== 4'b0) begin n_fail++; $display("FAIL stall_no_grant i=%0d got=%b exp=0000", i, s_req_ready); end
            n_checks++;
            if (s_rsp_valid !== 4'b0010) begin n_fail++; $display("FAIL stall_rsp_valid i=%0d got=%b exp=0010", i, s_rsp_valid); end
            n_checks++;
            if (s_rsp_data !== ref_mul(8'd17, 16'hFC18)) begin
                n_fail++;
                $display("FAIL stall_rsp_data i=%0d got=%h exp=%h", i, s_rsp_data, ref_mul(8'd17, 16'hFC18));
            end
        end
        rsp_ready = 4'b1111;
        req_valid = 4'b0;
        repeat (6) cycle();
    endtask

    task automatic test_reset_midflight();
        rsp_ready = 4'b1111;
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            cycle();
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (rsp_valid !== 4'b0) begin n_fail++; $display("FAIL midreset_rsp_valid got=%b exp=0000", rsp_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        n_checks++;
        if (req_ready !== 4'b0) begin n_fail++; $display("FAIL midreset_req_ready got=%b exp=0000", req_ready); end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 4'b0;
        model_reset();
        repeat (6) cycle();
    endtask

`ifdef CONVOLVE_FPGA_MUL_ARB_PRIO0_EN
    task automatic test_prio();
        pulse_reset();
        rsp_ready = 4'b1111;
        req_valid = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            cycle();
            n_checks++;
            if (s_req_ready !== 4'b0001) begin n_fail++; $display("FAIL prio_lane0 i=%0d got=%b exp=0001", i, s_req_ready); end
        end
        req_valid = 4'b1000;
        cycle();
        n_checks++;
        if (s_req_ready !== 4'b1000) begin n_fail++; $display("FAIL prio_lane3 got=%b exp=1000", s_req_ready); end
        req_valid = 4'b0;
        repeat (4) cycle();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom());
            for (int l = 0; l < NR; l++) rsp_ready[l] = ($urandom_range(0, 3) != 0);
            rand_ops();
            cycle();
        end
        req_valid = 4'b0;
        rsp_ready = 4'b1111;
        repeat (8) cycle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_stall();
        test_reset_midflight();
`ifdef CONVOLVE_FPGA_MUL_ARB_PRIO0_EN
        test_prio();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/convolve_fpga_mul_arbiter.md
# convolve_fpga_mul_arbiter

Shares one pipelined 8u×16s→16 multiplier core among `NUM_REQ` convolution-lane requesters. It arbitrates operand requests, tracks the owner of each in-flight product through the pipeline, and returns each result to its owner with per-lane valid/ready. It holds the whole pipeline when the owner of the head result is not ready. It sits between the convolution lane controllers and the single `convolve_fpga_mul_mul_8ns_16s_16_4_1` instance, and drives that instance's `ce`.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `MUL_LAT`, default 3: clock edges from operands presented to product on core `dout` with `ce` high.
- `ID_W`, default `$clog2(NUM_REQ)`: owner-tag width.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `NUM_REQ`: lane i has operands.
- `req_ready`, out, `NUM_REQ`: lane i granted this cycle; one-hot or zero.
- `req_a`, in, `NUM_REQ*8`: unsigned pixel operand; lane i is at `[8i+7:8i]`.
- `req_b`, in, `NUM_REQ*16`: signed coefficient; lane i is at `[16i+15:16i]`.
- `rsp_valid`, out, `NUM_REQ`: product for lane i is on `rsp_data`; one-hot or zero.
- `rsp_ready`, in, `NUM_REQ`: lane i accepts its product.
- `rsp_data`, out, 16: product, shared by all lanes.
- `busy`, out, 1: at least one tag pipeline stage is valid.

## Operation
- **Tag pipeline.** `MUL_LAT` stages of {valid, id}.
  - Stage 0 loads the grant; the last stage is the head.
  - All stages shift only when `ce` is high, in lockstep with the core.
- **Stall.** `ce = !(head_valid && !rsp_ready[head_id])`.
  - When `ce` is low: no grant, all tags hold, and the core holds its registers.
- **Grant.**
  - Enabled when `ce` is high and `req_valid` is non-zero.
  - Round-robin from pointer `rr`: the first requesting lane at or after `rr` wins, searching modulo `NUM_REQ`.
  - `req_ready[winner]=1`, the mux drives the winner's operands to core `din0`/`din1`, and stage 0 takes {1, winner}.
  - Then `rr <= winner+1`, wrapping to 0 after `NUM_REQ-1`.
  - No requester, or `ce` low: stage 0 takes {0, –} and `rr` holds.
- **Response.**
  - `rsp_valid[i] = head_valid && head_id==i`.
  - `rsp_data` = core `dout`.
  - The transfer completes when `rsp_valid[i] && rsp_ready[i]`.
- **Arithmetic.** `rsp_data` is the low 16 bits of `$signed({1'b0,a}) * $signed(b)`. It wraps with no saturation.
- **Simultaneous events.** A grant and a head transfer in the same cycle are legal and give full throughput of one result per cycle.
- **Reset** (asynchronous, allowed mid-operation):
  - All tag valids are cleared, `rr` is set to 0, and all outputs go to 0.
  - In-flight products are discarded.
  - Core data registers are not reset; the cleared tags mask them.
  - Requesters must re-issue after reset.
- **Operand stability.** Operands need be stable only in the grant cycle.

## Timing
- **Reset values:** `req_ready=0`, `rsp_valid=0`, `busy=0`, `rr=0`. `rsp_data` is undefined until the first product (core output).
- **Grant path:** `req_ready` is combinational from `req_valid`, `rr`, and `ce`.
- **Latency:** a grant in cycle T gives `rsp_valid` in cycle T+`MUL_LAT` (T+3) when there are no stalls. Each stall cycle adds exactly one cycle.
- **Throughput:** one grant per cycle while `ce=1`.
- **Response hold:** a held head keeps `rsp_valid` and `rsp_data` stable until accepted.
- **`busy`:** registered OR of the stage valids.

## Configuration
- **`CONVOLVE_FPGA_MUL_ARB_PRIO0_EN`** defined: lane 0 has strict priority. Whenever `req_valid[0]=1` and `ce=1`, lane 0 is granted and `rr` is unchanged. Other lanes use round-robin among the remaining lanes.
- **Macro undefined:** pure round-robin over all lanes, as described in Operation.

## Structure
- **Shared package `convolve_fpga_pkg`** holds:
  - Widths: `MUL_A_W=8`, `MUL_B_W=16`, `MUL_P_W=16`, `MUL_LAT=3`.
  - The `mul_tag_t` struct {valid, id}.
- **Sub-module `convolve_fpga_rr_pick`:** combinational round-robin picker, from request vector and pointer to one-hot grant plus index. It is parameterised on `NUM_REQ`.
- **Core:** the `convolve_fpga_mul_mul_8ns_16s_16_4_1` core is instantiated directly, with `reset` tied to the block's `reset`.

## Test plan
- **Single request:** after reset, lane 2 requests a=200, b=-3 in cycle 5. Expect `req_ready[2]` in cycle 5, then `rsp_valid[2]` and `rsp_data=-600` (16'hFDA8) in cycle 8.
- **Round-robin:** all 4 lanes hold `req_valid` with `rsp_ready` all 1. Expect grants in order 0,1,2,3,0,…, one per cycle, and responses in the same order 3 cycles later.
- **Wrap:** a=255, b=32767. Expect `rsp_data=16'h7F01`, the low 16 bits of 8355585.
- **Stall:** the head result is owned by lane 1 and `rsp_ready[1]=0` for 4 cycles. Expect:
  - no grants during those cycles;
  - `rsp_data` and `rsp_valid` stable;
  - on release, the remaining in-flight results emerge in order with no loss or duplication.
- **Reset mid-flight:** assert `reset` with 3 products in flight. Expect `rsp_valid=0` and `busy=0` immediately, and no stale response after deassertion.
- **Priority macro:** with `CONVOLVE_FPGA_MUL_ARB_PRIO0_EN` defined, lanes 0 and 3 request continuously. Expect lane 0 granted every cycle and lane 3 granted only when lane 0 drops.
